// File: rtl/cache_defs.sv
// rtl/cache_defs.sv - shared cache/memory arbiter types and grant encoding
package cache_defs;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_DCACHE,
        ARB_ICACHE
    } type_mem_arb_states_e;

    localparam logic GRANT_ICACHE = 1'b0;
    localparam logic GRANT_DCACHE = 1'b1;

endpackage

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin arbiter sharing the memory port between icache and dcache
module cache_mem_arbiter
    import cache_defs::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache2mem_req_i,
    input  logic [ADDR_W-1:0] icache2mem_addr_i,
    input  logic              icache2mem_kill_i,
    output logic              mem2icache_ack_o,
    output logic [LINE_W-1:0] mem2icache_data_o,
    input  logic              dcache2mem_req_i,
    input  logic              dcache2mem_wr_i,
    input  logic [ADDR_W-1:0] dcache2mem_addr_i,
    input  logic [LINE_W-1:0] dcache2mem_data_i,
    input  logic              dcache2mem_kill_i,
    output logic              mem2dcache_ack_o,
    output logic [LINE_W-1:0] mem2dcache_data_o,
    output logic              mem_req_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_kill_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i
);

    type_mem_arb_states_e state_q, state_d;
    logic                 last_grant_q, last_grant_d;

    logic own_d, own_i, own_req, own_kill, abort, done;
    logic d_cand, i_cand, pick_d;

    assign mem2icache_data_o = mem_data_i;
    assign mem2dcache_data_o = mem_data_i;

    always_comb begin
        own_d    = (state_q == ARB_DCACHE);
        own_i    = (state_q == ARB_ICACHE);
        own_req  = (own_d & dcache2mem_req_i)  | (own_i & icache2mem_req_i);
        own_kill = (own_d & dcache2mem_kill_i) | (own_i & icache2mem_kill_i);
        // A dropped request without ack is treated like a kill so memory never keeps a stale transaction.
        abort    = (own_d | own_i) & (own_kill | ~own_req);
        done     = (own_d | own_i) & ~abort & mem_ack_i;

        mem_req_o        = (own_d | own_i) & ~abort;
        mem_kill_o       = abort;
        mem_wr_o         = own_d & dcache2mem_wr_i;
        mem_addr_o       = own_d ? dcache2mem_addr_i : (own_i ? icache2mem_addr_i : '0);
        mem_data_o       = own_d ? dcache2mem_data_i : '0;
        mem2dcache_ack_o = own_d & done;
        mem2icache_ack_o = own_i & done;

        d_cand = dcache2mem_req_i & ~dcache2mem_kill_i;
        i_cand = icache2mem_req_i & ~icache2mem_kill_i;
        pick_d = d_cand & (~i_cand | (last_grant_q == GRANT_ICACHE));

        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_d) begin
                    state_d = ARB_DCACHE;
                end else if (i_cand) begin
                    state_d = ARB_ICACHE;
                end
            end
            default: begin
                if (abort | done) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = own_d ? GRANT_DCACHE : GRANT_ICACHE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GRANT_ICACHE;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ireq, ikill, dreq, dwr, dkill, mem_ack_i;
    logic [ADDR_W-1:0] iaddr, daddr;
    logic [LINE_W-1:0] ddata, mem_data_i;
    logic              iack, dack, mem_req, mem_wr, mem_kill;
    logic [LINE_W-1:0] idata_o, ddata_o, mem_data_o;
    logic [ADDR_W-1:0] mem_addr;

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .icache2mem_req_i  (ireq),
        .icache2mem_addr_i (iaddr),
        .icache2mem_kill_i (ikill),
        .mem2icache_ack_o  (iack),
        .mem2icache_data_o (idata_o),
        .dcache2mem_req_i  (dreq),
        .dcache2mem_wr_i   (dwr),
        .dcache2mem_addr_i (daddr),
        .dcache2mem_data_i (ddata),
        .dcache2mem_kill_i (dkill),
        .mem2dcache_ack_o  (dack),
        .mem2dcache_data_o (ddata_o),
        .mem_req_o         (mem_req),
        .mem_wr_o          (mem_wr),
        .mem_addr_o        (mem_addr),
        .mem_data_o        (mem_data_o),
        .mem_kill_o        (mem_kill),
        .mem_ack_i         (mem_ack_i),
        .mem_data_i        (mem_data_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: who owns the port (0 none, 1 dcache, 2 icache) and who was served last (1 = dcache).
    int   m_owner = 0;
    bit   m_last  = 1'b0;
    logic e_dack, e_iack;
    logic s_mreq, s_mkill, s_mwr, s_dack, s_iack;
    logic [ADDR_W-1:0] s_maddr;
    logic [LINE_W-1:0] s_mdata;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        logic e_req, e_kill, e_wr, o_req, o_kill, aborted, dc, ic;
        logic [ADDR_W-1:0] e_addr;
        logic [LINE_W-1:0] e_data;
        int  nxt_owner;
        bit  nxt_last;
        @(negedge clk);
        e_req = 0; e_kill = 0; e_wr = 0; e_addr = '0; e_data = '0;
        e_dack = 0; e_iack = 0;
        nxt_owner = m_owner; nxt_last = m_last;
        if (!rst_n) begin
            nxt_owner = 0; nxt_last = 0;
        end else if (m_owner == 0) begin
            dc = dreq && !dkill;
            ic = ireq && !ikill;
            if (dc && ic)  nxt_owner = m_last ? 2 : 1;
            else if (dc)   nxt_owner = 1;
            else if (ic)   nxt_owner = 2;
        end else begin
            o_req   = (m_owner == 1) ? dreq  : ireq;
            o_kill  = (m_owner == 1) ? dkill : ikill;
            aborted = o_kill || !o_req;
            e_req   = !aborted;
            e_kill  = aborted;
            e_addr  = (m_owner == 1) ? daddr : iaddr;
            if (m_owner == 1) begin
                e_wr = dwr; e_data = ddata;
            end
            if (!aborted && mem_ack_i) begin
                if (m_owner == 1) e_dack = 1; else e_iack = 1;
            end
            if (aborted || mem_ack_i) begin
                nxt_owner = 0;
                nxt_last  = (m_owner == 1);
            end
        end
        chk("mem_req",  mem_req,    e_req);
        chk("mem_kill", mem_kill,   e_kill);
        chk("mem_wr",   mem_wr,     e_wr);
        chk("mem_addr", mem_addr,   e_addr);
        chk("mem_data", mem_data_o, e_data);
        chk("dack",     dack,       e_dack);
        chk("iack",     iack,       e_iack);
        chk("idata",    idata_o,    mem_data_i);
        chk("ddata",    ddata_o,    mem_data_i);
        s_mreq = mem_req; s_mkill = mem_kill; s_mwr = mem_wr; s_dack = dack; s_iack = iack;
        s_maddr = mem_addr; s_mdata = mem_data_o;
        @(posedge clk);
        #1;
        m_owner = nxt_owner;
        m_last  = nxt_last;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] order;
        int         nreq, na, r;
        bit         got;

        rst_n = 0; ireq = 0; ikill = 0; dreq = 0; dwr = 0; dkill = 0; mem_ack_i = 0;
        iaddr = 32'h1000_0000; daddr = 32'h2000_0000; ddata = '0; mem_data_i = {4{32'hDEAD_BEEF}};
        cycle(); cycle();
        rst_n = 1;
        cycle();

        // Tie straight after reset: dcache first, then alternation.
        order = '0; na = 0;
        for (int rd = 0; rd < 2; rd++) begin
            dreq = 1; ireq = 1; mem_ack_i = 1;
            for (int k = 0; k < 12 && (dreq || ireq); k++) begin
                cycle();
                if (s_dack) begin order = {order[2:0], 1'b1}; na++; dreq = 0; end
                if (s_iack) begin order = {order[2:0], 1'b0}; na++; ireq = 0; end
            end
            dreq = 0; ireq = 0; mem_ack_i = 0;
            cycle();
        end
        chk("tie_order", order, 4'b1010);
        chk("tie_acks", na, 4);

        // Dcache allocate alone, ack on the fourth owned cycle.
        nreq = 0;
        dreq = 1; dwr = 0; daddr = 32'h0000_1240;
        cycle(); nreq += s_mreq;
        for (int k = 0; k < 3; k++) begin cycle(); nreq += s_mreq; end
        mem_ack_i = 1; cycle(); nreq += s_mreq;
        chk("dc_alone_ack", s_dack, 1'b1);
        chk("dc_alone_wr", s_mwr, 1'b0);
        dreq = 0; mem_ack_i = 0; cycle(); nreq += s_mreq;
        chk("dc_alone_req_cycles", nreq, 4);

        // Write-back, then allocate waits behind a pending icache fill.
        dreq = 1; dwr = 1; daddr = 32'h8000_0040; ddata = {16{8'hA5}};
        cycle();
        ireq = 1; iaddr = 32'h3000_0100;
        cycle();
        chk("wb_addr", s_maddr, 32'h8000_0040);
        chk("wb_data", s_mdata, {16{8'hA5}});
        chk("wb_wr", s_mwr, 1'b1);
        mem_ack_i = 1; cycle();
        chk("wb_ack", s_dack, 1'b1);
        dwr = 0; daddr = 32'h8000_0080;
        got = 0;
        for (int k = 0; k < 12 && !got; k++) begin
            cycle();
            if (s_iack || s_dack) begin got = 1; chk("alloc_after_icache", s_iack, 1'b1); end
        end
        chk("first_ack_seen", got, 1'b1);
        ireq = 0;
        got = 0;
        for (int k = 0; k < 12 && !got; k++) begin
            cycle();
            if (s_dack) got = 1;
        end
        chk("alloc_ack_seen", got, 1'b1);
        dreq = 0; mem_ack_i = 0; cycle();

        // Kill beats ack on the icache owner.
        ireq = 1; cycle(); cycle();
        ikill = 1; mem_ack_i = 1; cycle();
        chk("kill_pulse", s_mkill, 1'b1);
        chk("kill_req_low", s_mreq, 1'b0);
        chk("kill_no_ack", s_iack, 1'b0);
        ireq = 0; ikill = 0; mem_ack_i = 0; cycle();
        chk("kill_idle", s_mreq, 1'b0);

        // Non-owner kill is ignored; stray ack in idle produces nothing.
        ireq = 1; cycle();
        dreq = 1; dkill = 1; cycle();
        chk("nonowner_kill", s_mkill, 1'b0);
        dreq = 0; dkill = 0; mem_ack_i = 1; cycle();
        chk("owner_completes", s_iack, 1'b1);
        ireq = 0; cycle();
        chk("stray_ack", {s_iack, s_dack}, 2'b00);
        mem_ack_i = 0;

        // Make dcache the last served, then reset in the middle of an icache fill.
        dreq = 1; cycle(); mem_ack_i = 1; cycle(); dreq = 0; mem_ack_i = 0; cycle();
        ireq = 1; cycle(); cycle();
        #2;
        chk("pre_reset_req", mem_req, 1'b1);
        rst_n = 0;
        #1;
        chk("async_rst_req", mem_req, 1'b0);
        chk("async_rst_addr", mem_addr, '0);
        chk("async_rst_misc", {mem_kill, mem_wr, iack, dack}, 4'b0000);
        m_owner = 0; m_last = 0;
        cycle();
        dreq = 1; daddr = 32'h4444_0000; rst_n = 1;
        cycle(); cycle();
        chk("post_rst_dcache", s_maddr, 32'h4444_0000);
        dreq = 0; ireq = 0; cycle();

        // Random traffic against the reference model.
        for (int c = 0; c < 2500; c++) begin
            mem_ack_i  = ($urandom_range(99) < 30);
            mem_data_i = {$urandom, $urandom, $urandom, $urandom};
            cycle();
            if (dkill) begin
                dkill = 0; dreq = 0;
            end else if (dreq) begin
                if (e_dack) dreq = 0;
                else begin
                    r = $urandom_range(99);
                    if (r < 4) dkill = 1; else if (r < 6) dreq = 0;
                end
            end else if ($urandom_range(99) < 30) begin
                dreq = 1; dwr = $urandom_range(1); daddr = $urandom;
                ddata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (ikill) begin
                ikill = 0; ireq = 0;
            end else if (ireq) begin
                if (e_iack) ireq = 0;
                else begin
                    r = $urandom_range(99);
                    if (r < 4) ikill = 1; else if (r < 6) ireq = 0;
                end
            end else if ($urandom_range(99) < 30) begin
                ireq = 1; iaddr = $urandom;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path and the write-back data-cache controller (line write-back and line allocate).
- Sits between the two cache controllers and the memory/bus interface.
- Grants one requester per transaction, holds the grant until ack or kill, and uses round-robin on ties.
- Forwards kill signalling so an aborted cache request never leaves a stale transaction on memory.

Parameters:
ADDR_W, 32, physical address width
LINE_W, 128, cache line width in bits (read and write data)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
icache2mem_req_i  in  1  icache line-fill request, held until ack or kill
icache2mem_addr_i  in  ADDR_W  icache line address
icache2mem_kill_i  in  1  icache aborts its request
mem2icache_ack_o  out  1  fill complete
mem2icache_data_o  out  LINE_W  fill data
dcache2mem_req_i  in  1  dcache request, held until ack or kill
dcache2mem_wr_i  in  1  1 = write-back, 0 = allocate
dcache2mem_addr_i  in  ADDR_W  dcache line address
dcache2mem_data_i  in  LINE_W  write-back data
dcache2mem_kill_i  in  1  dcache aborts its request
mem2dcache_ack_o  out  1  dcache transaction complete
mem2dcache_data_o  out  LINE_W  allocate data
mem_req_o  out  1  request to memory
mem_wr_o  out  1  write enable to memory
mem_addr_o  out  ADDR_W  address to memory
mem_data_o  out  LINE_W  write data to memory
mem_kill_o  out  1  abort the current memory transaction (1-cycle pulse)
mem_ack_i  in  1  memory completion (1-cycle pulse)
mem_data_i  in  LINE_W  memory read data

Behaviour:
- States: ARB_IDLE, ARB_DCACHE, ARB_ICACHE. Registers: state_ff, last_grant_ff (0 = icache, 1 = dcache).
- Reset (asynchronous, rst_n = 0):
  - state_ff = ARB_IDLE; last_grant_ff = 0, so dcache wins the first tie.
  - All mem_* outputs and both acks are 0.
  - An in-flight transaction is abandoned. No kill is issued; memory is reset with the same rst_n.
- ARB_IDLE:
  - mem_req_o = 0 and all outputs are 0.
  - Only dcache requesting (req & ~kill) -> ARB_DCACHE.
  - Only icache requesting -> ARB_ICACHE.
  - Both requesting -> grant the one not equal to last_grant_ff.
  - A request and its kill in the same cycle -> that request is not considered.
- Grant latency: a request sampled in IDLE at cycle N gives mem_req_o = 1 at cycle N+1.
  - Minimum turnaround: 1 idle cycle between transactions.
- ARB_DCACHE / ARB_ICACHE (owner = granted side):
  - mem_req_o = owner req. mem_addr_o = owner addr.
  - mem_wr_o = dcache2mem_wr_i in ARB_DCACHE; 0 in ARB_ICACHE.
  - mem_data_o = dcache2mem_data_i in ARB_DCACHE; 0 in ARB_ICACHE.
  - All of these are combinational from owner inputs.
- mem_ack_i = 1 (and no owner kill):
  - Owner ack_o = 1 in the same cycle.
  - Next state ARB_IDLE; last_grant_ff <= owner.
- Owner kill, or owner req deasserted without ack:
  - mem_kill_o = 1 and mem_req_o = 0 that cycle.
  - Next state ARB_IDLE; last_grant_ff <= owner.
  - An ack in the same cycle is dropped; owner ack_o = 0. Kill beats ack.
- Non-owner:
  - ack_o is always 0; its kill is ignored while the other side owns the port.
  - It keeps its request pending.
- mem_ack_i in ARB_IDLE is dropped; no ack output.
- mem2icache_data_o = mem2dcache_data_o = mem_data_i, unconditionally. Consumers qualify the data with their own ack.
- Grant is not locked across dcache write-back then allocate:
  - The dcache re-requests after the write-back ack.
  - A pending icache request is served in between, because of round-robin.
- Outputs are glitch-relevant only to owner inputs. No combinational path from non-owner inputs to mem_*.

Decomposition:
- Shared package (cache_defs) gets:
  - typedef enum type_mem_arb_states_e {ARB_IDLE, ARB_DCACHE, ARB_ICACHE}
  - grant encoding constants GRANT_ICACHE = 1'b0, GRANT_DCACHE = 1'b1
- Single module; no sub-module. The round-robin pick is one expression.

Test Plan:
- Dcache alone: allocate req at cycle 2, mem_ack_i at cycle 6 -> mem_req_o high cycles 3-6, mem_wr_o = 0, mem2dcache_ack_o only at cycle 6, IDLE at cycle 7.
- Simultaneous icache + dcache req after reset -> dcache granted first. After its ack, icache granted with 1 idle cycle gap. Repeat the tie -> grants alternate D, I, D, I.
- Dcache write-back (wr = 1, addr 0x8000_0040, data 0xA5..A5) -> mem_wr_o = 1, mem_addr_o / mem_data_o match exactly. The dcache allocate that follows waits behind a pending icache request.
- Icache owner kill at cycle 4 while mem_ack_i also pulses at cycle 4 -> mem_kill_o = 1, mem_req_o = 0, mem2icache_ack_o = 0 at cycle 4, IDLE at cycle 5.
- Dcache kill asserted while icache owns the port -> no mem_kill_o, icache transaction completes normally. Stray mem_ack_i in IDLE -> no ack outputs.
- rst_n dropped mid-transaction, asynchronously between clock edges -> all outputs go to 0 immediately, without waiting for a clock edge. After release, a tie grants dcache.
